// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-display path.
// Holds the BCD digit type, the converter FSM encoding and the digit-count helper.
package perf_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd_state_e;

    localparam int CLK_50_HZ = 50_000_000;

    // Smallest d with 10^d > 2^bin_width; evaluated at elaboration only.
    function automatic int min_bcd_digits(input int bin_width);
        logic [255:0] pow2;
        logic [255:0] pow10;
        int           d;
        pow2  = 256'd1 << bin_width;
        pow10 = 256'd1;
        d     = 0;
        while (pow10 <= pow2) begin
            pow10 = pow10 * 256'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust
    import perf_pkg::*;
(
    input  bcd_digit_t digit_value,
    output bcd_digit_t adjusted
);

    assign adjusted = (digit_value >= 4'd5) ? digit_value + 4'd3 : digit_value;

endmodule

// File: rtl/perf_bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with a periodic refresh request.
// Results are double-buffered so the digit selector always sees a complete value.
module perf_bcd_converter
    import perf_pkg::*;
#(
    parameter int BIN_WIDTH      = 32,
    parameter int NUM_DIGITS     = 10,
    parameter int REFRESH_PERIOD = 5_000_000
) (
    input  logic                    CLK_50,
    input  logic                    reset,
    input  logic [BIN_WIDTH-1:0]    bin_value,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd_digits,
    output logic [NUM_DIGITS-1:0]   lz_mask,
    output bcd_state_e              state_dbg
);

    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
    localparam logic [NUM_DIGITS-1:0] LZ_RESET = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

    if (NUM_DIGITS < min_bcd_digits(BIN_WIDTH)) begin : g_bad_digits
        $error("NUM_DIGITS too small to hold every BIN_WIDTH value");
    end

    bcd_state_e                state;
    logic [BIN_WIDTH-1:0]      shift_reg;
    logic [4*NUM_DIGITS-1:0]   scratch;
    logic [CW-1:0]             bit_cnt;
    logic [RW-1:0]             refresh_cnt;
    logic                      refresh_pending;

    logic [4*NUM_DIGITS-1:0]   adj;
    logic [4*NUM_DIGITS-1:0]   scratch_next;
    logic [BIN_WIDTH-1:0]      shift_next;
    logic [NUM_DIGITS-1:0]     lz_next;
    logic                      refresh_tick;
    logic                      launch;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_value (scratch[4*i +: 4]),
            .adjusted    (adj[4*i +: 4])
        );
    end

    assign {scratch_next, shift_next} = {adj, shift_reg} << 1;

    // Bit i set when digit i and everything above it is zero; digit 0 is always shown.
    always_comb begin
        logic all_zero;
        lz_next  = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero && (scratch_next[4*i +: 4] == 4'd0);
            lz_next[i] = all_zero;
        end
    end

    // The wrap itself counts as a request so the first auto launch lands on the wrap edge.
    assign refresh_tick = (REFRESH_PERIOD != 0) && (refresh_cnt == REFRESH_LAST);

    // start is a request with no ready: sampled only in IDLE, dropped otherwise.
    // done is a one-cycle pulse marking bcd_digits/lz_mask as freshly valid.
    assign launch    = (state == IDLE) && (start || refresh_pending || refresh_tick);
    assign state_dbg = state;

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state           <= IDLE;
            shift_reg       <= '0;
            scratch         <= '0;
            bit_cnt         <= '0;
            refresh_cnt     <= '0;
            refresh_pending <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            bcd_digits      <= '0;
            lz_mask         <= LZ_RESET;
        end else begin
            done <= 1'b0;

            if (REFRESH_PERIOD != 0) begin
                if (refresh_tick) begin
                    refresh_cnt <= '0;
                end else begin
                    refresh_cnt <= refresh_cnt + 1'b1;
                end
            end

            if (launch) begin
                refresh_pending <= 1'b0;
            end else if (refresh_tick) begin
                refresh_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (launch) begin
                        shift_reg <= bin_value;
                        scratch   <= '0;
                        bit_cnt   <= CW'(BIN_WIDTH);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= scratch_next;
                    shift_reg <= shift_next;
                    bit_cnt   <= bit_cnt - 1'b1;
                    if (bit_cnt == CW'(1)) begin
                        bcd_digits <= scratch_next;
                        lz_mask    <= lz_next;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_bcd_converter.sv
// Directed bench for perf_bcd_converter: one instance without auto-refresh, one with a
// 100-clock refresh period; expected values are hand-computed decimal conversions.
module tb_perf_bcd_converter;
    import perf_pkg::*;

    logic        clk;
    logic        reset0, start0;
    logic [31:0] bin0;
    logic        busy0, done0;
    logic [39:0] bcd0;
    logic [9:0]  lz0;
    bcd_state_e  st0;

    logic        reset1, start1;
    logic [31:0] bin1;
    logic        busy1, done1;
    logic [39:0] bcd1;
    logic [9:0]  lz1;
    bcd_state_e  st1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] launch_q[$];

    perf_bcd_converter #(.BIN_WIDTH(32), .NUM_DIGITS(10), .REFRESH_PERIOD(0)) dut0 (
        .CLK_50(clk), .reset(reset0), .bin_value(bin0), .start(start0),
        .busy(busy0), .done(done0), .bcd_digits(bcd0), .lz_mask(lz0), .state_dbg(st0)
    );

    perf_bcd_converter #(.BIN_WIDTH(32), .NUM_DIGITS(10), .REFRESH_PERIOD(100)) dut1 (
        .CLK_50(clk), .reset(reset1), .bin_value(bin1), .start(start1),
        .busy(busy1), .done(done1), .bcd_digits(bcd1), .lz_mask(lz1), .state_dbg(st1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse start on dut0 and wait (bounded) for done; returns latency and busy-cycle count.
    task automatic run0(input logic [31:0] val, output int lat, output int busy_cnt);
        bin0   = val;
        start0 = 1'b1;
        @(negedge clk);
        start0   = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (lat < 60) begin
            if (busy0) busy_cnt++;
            @(negedge clk);
            lat++;
            if (done0) break;
        end
    endtask

    initial begin
        int lat, bc, dcount, first, cyc;
        logic prev_busy;

        reset0 = 1'b1; start0 = 1'b0; bin0 = '0;
        reset1 = 1'b1; start1 = 1'b0; bin1 = 32'd100;
        repeat (3) @(negedge clk);

        check("rst_busy",  64'(busy0), 64'd0);
        check("rst_done",  64'(done0), 64'd0);
        check("rst_bcd",   64'(bcd0),  64'd0);
        check("rst_lz",    64'(lz0),   64'h3FE);
        check("rst_state", 64'(st0),   64'(IDLE));
        reset0 = 1'b0;
        @(negedge clk);

        // zero
        run0(32'd0, lat, bc);
        check("zero_lat",   64'(lat),   64'd32);
        check("zero_busy",  64'(bc),    64'd32);
        check("zero_bcd",   64'(bcd0),  64'd0);
        check("zero_lz",    64'(lz0),   64'h3FE);
        check("zero_bsyend",64'(busy0), 64'd0);
        @(negedge clk);
        check("zero_pulse", 64'(done0), 64'd0);

        // 12345
        run0(32'd12345, lat, bc);
        check("v12345_lat",  64'(lat),  64'd32);
        check("v12345_busy", 64'(bc),   64'd32);
        check("v12345_bcd",  64'(bcd0), 64'h00_0001_2345);
        check("v12345_lz",   64'(lz0),  64'h3E0);
        @(negedge clk);
        check("v12345_pulse", 64'(done0), 64'd0);

        // all ones
        run0(32'hFFFF_FFFF, lat, bc);
        check("max_lat", 64'(lat),  64'd32);
        check("max_bcd", 64'(bcd0), 64'h42_9496_7295);
        check("max_lz",  64'(lz0),  64'h000);
        @(negedge clk);

        // start re-pulsed and bin_value changed mid-conversion
        bin0 = 32'd55555; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        start0 = 1'b1; bin0 = 32'd7;
        @(negedge clk);
        start0 = 1'b0;
        dcount = 0; first = 0;
        for (int k = 6; k <= 60; k++) begin
            @(negedge clk);
            if (done0) begin
                dcount++;
                if (first == 0) first = k;
            end
        end
        check("restart_ndone", 64'(dcount), 64'd1);
        check("restart_lat",   64'(first),  64'd32);
        check("restart_bcd",   64'(bcd0),   64'h00_0005_5555);
        check("restart_lz",    64'(lz0),    64'h3E0);

        // reset during SHIFT
        bin0 = 32'd999; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        reset0 = 1'b1;
        @(negedge clk);
        check("abort_busy",  64'(busy0), 64'd0);
        check("abort_done",  64'(done0), 64'd0);
        check("abort_bcd",   64'(bcd0),  64'd0);
        check("abort_lz",    64'(lz0),   64'h3FE);
        check("abort_state", 64'(st0),   64'(IDLE));
        reset0 = 1'b0;
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done0) dcount++;
        end
        check("abort_nodone", 64'(dcount), 64'd0);
        run0(32'd4321, lat, bc);
        check("post_lat", 64'(lat),  64'd32);
        check("post_bcd", 64'(bcd0), 64'h00_0000_4321);
        check("post_lz",  64'(lz0),  64'h3F0);

        // auto-refresh every 100 clocks, forced start at 295 defers the tick at 300
        exp_q    = '{32'd132, 32'd232, 32'd327, 32'd360, 32'd432};
        launch_q = '{32'd100, 32'd200, 32'd295, 32'd328, 32'd400};
        reset1 = 1'b0;
        prev_busy = 1'b0;
        for (cyc = 1; cyc <= 440; cyc++) begin
            @(negedge clk);
            if (done1) begin
                if (exp_q.size() == 0) check("extra_done", 64'(cyc), 64'd0);
                else check("done_cycle", 64'(cyc), 64'(exp_q.pop_front()));
            end
            if (busy1 && !prev_busy) begin
                if (launch_q.size() == 0) check("extra_launch", 64'(cyc), 64'd0);
                else check("launch_cycle", 64'(cyc), 64'(launch_q.pop_front()));
            end
            prev_busy = busy1;
            if (cyc == 294) start1 = 1'b1;
            if (cyc == 295) start1 = 1'b0;
        end
        check("done_left",   64'(exp_q.size()),    64'd0);
        check("launch_left", 64'(launch_q.size()), 64'd0);
        check("auto_bcd",    64'(bcd1),            64'h00_0000_0100);
        check("auto_lz",     64'(lz1),             64'h3F8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
